// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the decode-stage branch-decision slice:
// condition codes, flag bit positions, the branch instruction class and field widths.
package branch_cond_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CC_W    = 4;
    localparam int unsigned IMM_W   = 24;
    localparam int unsigned OFFS_W  = 32;

    localparam int unsigned N_IDX = 3;
    localparam int unsigned Z_IDX = 2;
    localparam int unsigned C_IDX = 1;
    localparam int unsigned V_IDX = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [2:0] BRANCH_CLASS = 3'b101;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Condition evaluator: decides whether a 4-bit ARM condition holds for the {N,Z,C,V} flags.
module cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [3:0]      cond,
    input  logic [CC_W-1:0] flags,
    output logic            asserted
);

    logic n, z, c, v;

    always_comb begin
        n = flags[N_IDX];
        z = flags[Z_IDX];
        c = flags[C_IDX];
        v = flags[V_IDX];
    end

    always_comb begin
        asserted = 1'b0;
        case (cond)
            COND_EQ: asserted = z;
            COND_NE: asserted = ~z;
            COND_CS: asserted = c;
            COND_CC: asserted = ~c;
            COND_MI: asserted = n;
            COND_PL: asserted = ~n;
            COND_VS: asserted = v;
            COND_VC: asserted = ~v;
            COND_HI: asserted = c & ~z;
            COND_LS: asserted = ~c | z;
            COND_GE: asserted = (n == v);
            COND_LT: asserted = (n != v);
            COND_GT: asserted = ~z & (n == v);
            COND_LE: asserted = z | (n != v);
            COND_AL: asserted = 1'b1;
            COND_NV: asserted = 1'b0;
            default: asserted = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Decode-stage branch decision: condition check, B/BL detect, target-vs-nop select and
// word-offset sign extension, with a stallable registered copy for the next stage.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ld,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [CC_W-1:0]     cc_in,
    output logic                asserted,
    output logic                b_instr,
    output logic                choose_ta_r_nop,
    output logic [OFFS_W-1:0]   sex4_out,
    output logic                asserted_q,
    output logic                choose_ta_r_nop_q,
    output logic [OFFS_W-1:0]   sex4_out_q
);

    // Bit 24 (link) does not affect the branch decision or the offset.
    logic unused_link_bit;
    assign unused_link_bit = instr[24];

    cond_eval u_cond_eval (
        .cond     (instr[31:28]),
        .flags    (cc_in),
        .asserted (asserted)
    );

    always_comb begin
        b_instr         = (instr[27:25] == BRANCH_CLASS);
        choose_ta_r_nop = asserted & b_instr;
        sex4_out        = {{(OFFS_W-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
    end

    // Pipeline copy; reset clears it asynchronously, ld=0 stalls it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asserted_q        <= 1'b0;
            choose_ta_r_nop_q <= 1'b0;
            sex4_out_q        <= '0;
        end else if (ld) begin
            asserted_q        <= asserted;
            choose_ta_r_nop_q <= choose_ta_r_nop;
            sex4_out_q        <= sex4_out;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit.
module tb_branch_cond_unit;

    logic        clk;
    logic        reset_n;
    logic        ld;
    logic [31:0] instr;
    logic [3:0]  cc_in;
    logic        asserted;
    logic        b_instr;
    logic        choose_ta_r_nop;
    logic [31:0] sex4_out;
    logic        asserted_q;
    logic        choose_ta_r_nop_q;
    logic [31:0] sex4_out_q;

    int assertions = 0;
    int failures   = 0;

    branch_cond_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ld                (ld),
        .instr             (instr),
        .cc_in             (cc_in),
        .asserted          (asserted),
        .b_instr           (b_instr),
        .choose_ta_r_nop   (choose_ta_r_nop),
        .sex4_out          (sex4_out),
        .asserted_q        (asserted_q),
        .choose_ta_r_nop_q (choose_ta_r_nop_q),
        .sex4_out_q        (sex4_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table written as a bit-mask lookup rather than a case on cond.
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic [15:0] t;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        t = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
             ~v, v, ~n, n, ~c, c, ~z, z};
        return t[cond];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ld = 1'b1; instr = 32'hDB000001; cc_in = 4'b0011;
        tick();
        assertions++;
        if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== 34'd0) begin
            failures++;
            $display("FAIL reset_q: got %b/%b/%h expected 0/0/00000000",
                     asserted_q, choose_ta_r_nop_q, sex4_out_q);
        end
        assertions++;
        if (sex4_out !== 32'h00000004) begin
            failures++;
            $display("FAIL reset_comb_unaffected: sex4_out got %h expected 00000004", sex4_out);
        end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_le_branch();
        instr = 32'hDB000001; cc_in = 4'b0011; ld = 1'b1;
        #1;
        assertions++;
        if ({asserted, b_instr, choose_ta_r_nop} !== 3'b111) begin
            failures++;
            $display("FAIL le_comb: got %b%b%b expected 111", asserted, b_instr, choose_ta_r_nop);
        end
        assertions++;
        if (sex4_out !== 32'h00000004) begin
            failures++;
            $display("FAIL le_sex4: got %h expected 00000004", sex4_out);
        end
        tick();
        assertions++;
        if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== {2'b11, 32'h00000004}) begin
            failures++;
            $display("FAIL le_q: got %b/%b/%h expected 1/1/00000004",
                     asserted_q, choose_ta_r_nop_q, sex4_out_q);
        end
    endtask

    task automatic test_eq_neg_offset();
        instr = 32'h0A800000; cc_in = 4'b0000; ld = 1'b1;
        #1;
        assertions++;
        if ({asserted, b_instr, choose_ta_r_nop} !== 3'b010) begin
            failures++;
            $display("FAIL eq_comb: got %b%b%b expected 010", asserted, b_instr, choose_ta_r_nop);
        end
        assertions++;
        if (sex4_out !== 32'hFE000000) begin
            failures++;
            $display("FAIL eq_sex4: got %h expected FE000000", sex4_out);
        end
        tick();
        assertions++;
        if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== {2'b00, 32'hFE000000}) begin
            failures++;
            $display("FAIL eq_q: got %b/%b/%h expected 0/0/FE000000",
                     asserted_q, choose_ta_r_nop_q, sex4_out_q);
        end
        // Largest positive offset: 7FFFFF -> 01FFFFFC.
        instr = 32'hEA7FFFFF;
        #1;
        assertions++;
        if (sex4_out !== 32'h01FFFFFC || choose_ta_r_nop !== 1'b1) begin
            failures++;
            $display("FAIL max_pos_sex4: got %h/%b expected 01FFFFFC/1", sex4_out, choose_ta_r_nop);
        end
    endtask

    task automatic test_al_dataproc();
        instr = 32'hE0000000;
        for (int f = 0; f < 16; f += 5) begin
            cc_in = 4'(f);
            #1;
            assertions++;
            if ({asserted, b_instr, choose_ta_r_nop} !== 3'b100) begin
                failures++;
                $display("FAIL al_dp cc=%b: got %b%b%b expected 100",
                         cc_in, asserted, b_instr, choose_ta_r_nop);
            end
        end
    endtask

    task automatic test_cond_sweep();
        logic exp_a;
        for (int cd = 0; cd < 16; cd++) begin
            for (int f = 0; f < 16; f++) begin
                instr = {4'(cd), 4'b1010, 24'h000010};
                cc_in = 4'(f);
                #1;
                exp_a = ref_cond(4'(cd), 4'(f));
                if (cd == 15) exp_a = 1'b0;
                if (cd == 14) exp_a = 1'b1;
                assertions++;
                if (asserted !== exp_a || choose_ta_r_nop !== exp_a || b_instr !== 1'b1) begin
                    failures++;
                    $display("FAIL sweep cond=%h cc=%b: got a=%b b=%b t=%b expected a=%b b=1 t=%b",
                             cd, f, asserted, b_instr, choose_ta_r_nop, exp_a, exp_a);
                end
                // Same condition on a non-branch class never selects the target.
                instr[27:25] = 3'(cd % 5);
                #1;
                assertions++;
                if (asserted !== exp_a || b_instr !== 1'b0 || choose_ta_r_nop !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep_nb cond=%h cc=%b: got a=%b b=%b t=%b expected a=%b b=0 t=0",
                             cd, f, asserted, b_instr, choose_ta_r_nop, exp_a);
                end
            end
        end
    endtask

    task automatic test_reset_stall();
        instr = 32'hDB000001; cc_in = 4'b0011; ld = 1'b1;
        tick();
        assertions++;
        if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== {2'b11, 32'h00000004}) begin
            failures++;
            $display("FAIL preload_q: got %b/%b/%h expected 1/1/00000004",
                     asserted_q, choose_ta_r_nop_q, sex4_out_q);
        end
        #2 reset_n = 1'b0;
        #1;
        assertions++;
        if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== 34'd0) begin
            failures++;
            $display("FAIL async_reset_q: got %b/%b/%h expected 0/0/00000000",
                     asserted_q, choose_ta_r_nop_q, sex4_out_q);
        end
        #2 reset_n = 1'b1; ld = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            assertions++;
            if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== 34'd0) begin
                failures++;
                $display("FAIL stall_q edge%0d: got %b/%b/%h expected 0/0/00000000",
                         e, asserted_q, choose_ta_r_nop_q, sex4_out_q);
            end
        end
        ld = 1'b1;
        tick();
        assertions++;
        if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== {2'b11, 32'h00000004}) begin
            failures++;
            $display("FAIL reload_q: got %b/%b/%h expected 1/1/00000004",
                     asserted_q, choose_ta_r_nop_q, sex4_out_q);
        end
        // Stall holds a nonzero value while inputs change.
        ld = 1'b0; instr = 32'h0A800000; cc_in = 4'b0000;
        tick();
        assertions++;
        if ({asserted_q, choose_ta_r_nop_q, sex4_out_q} !== {2'b11, 32'h00000004}) begin
            failures++;
            $display("FAIL hold_q: got %b/%b/%h expected 1/1/00000004",
                     asserted_q, choose_ta_r_nop_q, sex4_out_q);
        end
    endtask

    initial begin
        test_reset();
        test_le_branch();
        test_eq_neg_offset();
        test_al_dataproc();
        test_cond_sweep();
        test_reset_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
